// File: rtl/byte_serial_adder_pkg.sv
// Shared types and constants for the byte-serial adder.
package byte_serial_adder_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } bsa_state_t;

endpackage

// File: rtl/carry_select_adder8.sv
// Combinational 8-bit carry-select adder: ripple low nibble, pre-computed high nibble for both carries.
module carry_select_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    always_comb begin
        lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
        sum[3:0]         = lo[3:0];
        {cout, sum[7:4]} = lo[4] ? hi1 : hi0;
    end

endmodule

// File: rtl/byte_serial_adder.sv
// WIDTH-bit adder computed one byte per cycle through a single 8-bit slice.
// Define BYTE_SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned BEATS = WIDTH / BYTE_W;
    localparam int unsigned BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    bsa_state_t       state;
    bsa_state_t       state_nx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry_q;
    logic [BW-1:0]    beat;
    logic [BW+2:0]    lsb;
    logic [7:0]       lane_a;
    logic [7:0]       lane_b;
    logic [7:0]       lane_sum;
    logic             lane_cout;
    logic             last_beat;

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        lsb       = {beat, 3'b000};
        lane_a    = opa[lsb +: BYTE_W];
        lane_b    = opb[lsb +: BYTE_W];
        last_beat = (beat == LAST);
    end

    carry_select_adder8 u_slice (
        .a    (lane_a),
        .b    (lane_b),
        .cin  (carry_q),
        .cout (lane_cout),
        .sum  (lane_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_nx = ADD;
            ADD:     if (last_beat) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa       <= '0;
            opb       <= '0;
            carry_q   <= 1'b0;
            beat      <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        opa     <= a;
                        opb     <= b;
                        carry_q <= cin;
                        beat    <= '0;
                    end
                end
                ADD: begin
                    sum[lsb +: BYTE_W] <= lane_sum;
                    carry_q            <= lane_cout;
                    if (last_beat) begin
                        cout      <= lane_cout;
                        out_valid <= 1'b1;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
                        // Carry into the MSB recovered from the MSB sum bit being written this beat.
                        ovf       <= lane_sum[7] ^ opa[WIDTH-1] ^ opb[WIDTH-1] ^ lane_cout;
`endif
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Self-checking bench for byte_serial_adder against an arithmetic reference model.
module tb_byte_serial_adder;

    localparam int unsigned W     = 32;
    localparam int unsigned BEATS = W / 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    byte_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef BYTE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint lim;
        longint s;
        lim = longint'(1) <<< (W - 1);
        s   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        return (s >= lim) || (s < -lim);
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '1;
            1:       v = '0;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    function automatic logic dut_ovf();
`ifdef BYTE_SERIAL_ADDER_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          output logic [W-1:0] s, output logic co, output logic ov,
                          output int lat, output logic to);
        int n;
        to  = 1'b0;
        lat = 0;
        s   = '0;
        co  = 1'b0;
        ov  = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            to = 1'b1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            to = 1'b1;
            return;
        end
        s  = sum;
        co = cout;
        ov = dut_ovf();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== '0) begin fails++; $display("FAIL reset_sum got=%h exp=0", sum); end
        checks++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout got=%b exp=0", cout); end
`ifdef BYTE_SERIAL_ADDER_OVF_EN
        checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_fixed(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                              input logic [W-1:0] es, input logic ec, input logic eo);
        logic [W-1:0] s;
        logic co, ov, to;
        int lat;
        run_op(x, y, c, s, co, ov, lat, to);
        checks++; if (to !== 1'b0) begin fails++; $display("FAIL %s_timeout got=%b exp=0", name, to); end
        checks++; if (lat != BEATS) begin fails++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, BEATS); end
        checks++; if (s !== es) begin fails++; $display("FAIL %s_sum got=%h exp=%h", name, s, es); end
        checks++; if (co !== ec) begin fails++; $display("FAIL %s_cout got=%b exp=%b", name, co, ec); end
`ifdef BYTE_SERIAL_ADDER_OVF_EN
        checks++; if (ov !== eo) begin fails++; $display("FAIL %s_ovf got=%b exp=%b", name, ov, eo); end
`else
        if (eo === 1'bx) $display("unexpected model value");
`endif
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_ready_after got=%b exp=1", name, in_ready); end
    endtask

    task automatic test_backpressure();
        logic [W:0] exp;
        int n;
        @(negedge clk);
        a = rnd_word();
        b = rnd_word();
        cin = 1'($urandom);
        exp = ref_add(a, b, cin);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_reach_done got=%b exp=1", out_valid); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
            checks++; if ({cout, sum} !== exp) begin fails++; $display("FAIL bp_hold_sum cyc=%0d got=%h exp=%h", i, {cout, sum}, exp); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] s;
        logic co, ov, to;
        int lat;
        @(negedge clk);
        a = 32'h1234_5678;
        b = 32'h1111_1111;
        cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== '0) begin fails++; $display("FAIL midrst_sum got=%h exp=0", sum); end
        checks++; if (cout !== 1'b0) begin fails++; $display("FAIL midrst_cout got=%b exp=0", cout); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd5, 32'd7, 1'b0, s, co, ov, lat, to);
        checks++; if (to !== 1'b0) begin fails++; $display("FAIL postrst_timeout got=%b exp=0", to); end
        checks++; if ({co, s} !== 33'd12) begin fails++; $display("FAIL postrst_sum got=%h exp=%h", {co, s}, 33'd12); end
    endtask

    task automatic test_stream(input string name, input bit b2b, input int n);
        logic [W:0] q[$];
        logic       qo[$];
        logic [W:0] exp;
        logic       eo;
        int cyc, last_acc, sent, recv, gap;
        bit acc_prev;
        cyc = 0; last_acc = -1; sent = 0; recv = 0; gap = 0; acc_prev = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        while (recv < n && cyc < n * 30 + 100) begin
            @(negedge clk);
            if (acc_prev) in_valid = 1'b0;
            acc_prev = 1'b0;
            if (!in_valid && sent < n) begin
                if (gap > 0) gap--;
                else begin
                    in_valid = 1'b1;
                    a = rnd_word();
                    b = rnd_word();
                    cin = 1'($urandom);
                end
            end
            out_ready = b2b ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL %s_spurious got=%h exp=none", name, {cout, sum});
                end else begin
                    exp = q.pop_front();
                    eo = qo.pop_front();
                    if ({cout, sum} !== exp) begin fails++; $display("FAIL %s_result idx=%0d got=%h exp=%h", name, recv, {cout, sum}, exp); end
`ifdef BYTE_SERIAL_ADDER_OVF_EN
                    checks++;
                    if (ovf !== eo) begin fails++; $display("FAIL %s_ovf idx=%0d got=%b exp=%b", name, recv, ovf, eo); end
`endif
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_add(a, b, cin));
                qo.push_back(ref_ovf(a, b, cin));
                if (last_acc >= 0) begin
                    checks++;
                    if (b2b ? (cyc - last_acc != int'(BEATS + 2)) : (cyc - last_acc < int'(BEATS + 2))) begin
                        fails++; $display("FAIL %s_interval got=%0d exp=%0d", name, cyc - last_acc, BEATS + 2);
                    end
                end
                last_acc = cyc;
                sent++;
                acc_prev = 1'b1;
                gap = b2b ? 0 : $urandom_range(0, 3);
            end
            @(posedge clk);
            cyc++;
        end
        checks++; if (recv != n) begin fails++; $display("FAIL %s_count got=%0d exp=%0d", name, recv, n); end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        test_reset();
        test_fixed("basic", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        test_fixed("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        test_fixed("overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        test_fixed("neg_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        test_backpressure();
        test_reset_mid_op();
        test_stream("back_to_back", 1'b1, 8);
        test_stream("random", 1'b0, 1000);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
